// File: rtl/swg_pkg.sv
// Shared constants, quadrant type and quarter-wave table generator for the
// quadrature sine/cosine generator.
package swg_pkg;

    localparam int DEF_DW  = 11;
    localparam int DEF_PW  = 16;
    localparam int DEF_LAW = 6;
    localparam int DEF_AMP = 1000;

    typedef enum logic [1:0] {
        QUAD_0 = 2'd0,
        QUAD_1 = 2'd1,
        QUAD_2 = 2'd2,
        QUAD_3 = 2'd3
    } quad_t;

    localparam int     FRAC_BITS = 30;
    localparam longint PI_Q      = 64'd3373259426;

    // Fixed-point Taylor series keeps table generation free of real arithmetic;
    // entries are sampled at half-step offsets across the first quadrant.
    function automatic int lut_value(input int k, input int law, input int amp);
        longint x;
        longint x2;
        longint term;
        longint sum;
        x    = (PI_Q * longint'(2 * k + 1)) / (longint'(4) << law);
        x2   = (x * x) >>> FRAC_BITS;
        term = x;
        sum  = x;
        for (int i = 1; i <= 8; i++) begin
            term = -((term * x2) >>> FRAC_BITS) / longint'((2 * i) * (2 * i + 1));
            sum  = sum + term;
        end
        return int'((longint'(amp) * sum + (longint'(1) <<< (FRAC_BITS - 1))) >>> FRAC_BITS);
    endfunction

endpackage

// File: rtl/swg_qlut.sv
// Quarter-wave magnitude ROM with two independent registered read ports,
// one for the sine path and one for the cosine path.
module swg_qlut
    import swg_pkg::*;
#(
    parameter int MW  = DEF_DW - 1,
    parameter int LAW = DEF_LAW,
    parameter int AMP = DEF_AMP
) (
    input  logic           Clk,
    input  logic [LAW-1:0] sin_addr,
    input  logic [LAW-1:0] cos_addr,
    output logic [MW-1:0]  sin_mag,
    output logic [MW-1:0]  cos_mag
);

    localparam int N = 1 << LAW;

    logic [MW-1:0] rom_data [N];

    for (genvar i = 0; i < N; i++) begin : g_rom
        localparam logic [MW-1:0] ENTRY = MW'(lut_value(i, LAW, AMP));
        assign rom_data[i] = ENTRY;
    end

    always_ff @(posedge Clk) begin
        sin_mag <= rom_data[sin_addr];
        cos_mag <= rom_data[cos_addr];
    end

endmodule

// File: rtl/quad_swg.sv
// Quadrature sine/cosine generator: phase accumulator with a latched symbol
// offset, quarter-wave table lookup and a three-stage output pipeline.
module quad_swg
    import swg_pkg::*;
#(
    parameter int DW  = DEF_DW,
    parameter int PW  = DEF_PW,
    parameter int LAW = DEF_LAW,
    parameter int AMP = DEF_AMP
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          en,
    input  logic [PW-1:0] freq_word,
    input  logic [PW-1:0] phase_off,
    input  logic          sym_load,
    output logic [DW-1:0] sin_out,
    output logic [DW-1:0] cos_out,
    output logic          valid,
    output logic          wrap
);

    localparam int MW = DW - 1;
    localparam int TW = LAW + 2;

    if (AMP > (1 << (DW - 1)) - 1) begin : g_amp_check
        $error("quad_swg: AMP does not fit the signed output width");
    end

    if (PW < TW) begin : g_width_check
        $error("quad_swg: phase width too small for quadrant and table index");
    end

    logic [PW-1:0]  acc;
    logic [PW-1:0]  off_reg;
    logic [PW:0]    acc_next;
    logic [TW-1:0]  phase_top;
    quad_t          quad;
    logic [LAW-1:0] k_idx;

    logic           sin_fold;
    logic           sin_neg;
    logic           cos_fold;
    logic           cos_neg;

    logic           s1_valid;
    logic           s1_wrap;
    logic [LAW-1:0] s1_sin_addr;
    logic [LAW-1:0] s1_cos_addr;
    logic           s1_sin_neg;
    logic           s1_cos_neg;

    logic           s2_valid;
    logic           s2_wrap;
    logic           s2_sin_neg;
    logic           s2_cos_neg;
    logic [MW-1:0]  sin_mag;
    logic [MW-1:0]  cos_mag;
    logic [DW-1:0]  sin_pos;
    logic [DW-1:0]  cos_pos;

    assign acc_next  = {1'b0, acc} + {1'b0, freq_word};
    assign phase_top = TW'((acc + off_reg) >> (PW - TW));
    assign quad      = quad_t'(phase_top[TW-1 -: 2]);
    assign k_idx     = phase_top[LAW-1:0];

    // Cosine leads sine by one quadrant, so it uses the next quadrant's fold/sign.
    always_comb begin
        sin_fold = 1'b0;
        sin_neg  = 1'b0;
        cos_fold = 1'b0;
        cos_neg  = 1'b0;
        unique case (quad)
            QUAD_0: begin sin_fold = 1'b0; sin_neg = 1'b0; cos_fold = 1'b1; cos_neg = 1'b0; end
            QUAD_1: begin sin_fold = 1'b1; sin_neg = 1'b0; cos_fold = 1'b0; cos_neg = 1'b1; end
            QUAD_2: begin sin_fold = 1'b0; sin_neg = 1'b1; cos_fold = 1'b1; cos_neg = 1'b1; end
            QUAD_3: begin sin_fold = 1'b1; sin_neg = 1'b1; cos_fold = 1'b0; cos_neg = 1'b0; end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            acc         <= '0;
            off_reg     <= '0;
            s1_valid    <= 1'b0;
            s1_wrap     <= 1'b0;
            s1_sin_addr <= '0;
            s1_cos_addr <= '0;
            s1_sin_neg  <= 1'b0;
            s1_cos_neg  <= 1'b0;
        end else begin
            if (en) begin
                acc <= acc_next[PW-1:0];
            end
            if (sym_load) begin
                off_reg <= phase_off;
            end
            s1_valid    <= en;
            s1_wrap     <= en & acc_next[PW];
            s1_sin_addr <= sin_fold ? ~k_idx : k_idx;
            s1_cos_addr <= cos_fold ? ~k_idx : k_idx;
            s1_sin_neg  <= sin_neg;
            s1_cos_neg  <= cos_neg;
        end
    end

    swg_qlut #(
        .MW  (MW),
        .LAW (LAW),
        .AMP (AMP)
    ) u_qlut (
        .Clk      (Clk),
        .sin_addr (s1_sin_addr),
        .cos_addr (s1_cos_addr),
        .sin_mag  (sin_mag),
        .cos_mag  (cos_mag)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            s2_valid   <= 1'b0;
            s2_wrap    <= 1'b0;
            s2_sin_neg <= 1'b0;
            s2_cos_neg <= 1'b0;
        end else begin
            s2_valid   <= s1_valid;
            s2_wrap    <= s1_wrap;
            s2_sin_neg <= s1_sin_neg;
            s2_cos_neg <= s1_cos_neg;
        end
    end

    assign sin_pos = {1'b0, sin_mag};
    assign cos_pos = {1'b0, cos_mag};

    // Outputs only move on a valid sample so they hold through en gaps.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            sin_out <= '0;
            cos_out <= '0;
            valid   <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            valid <= s2_valid;
            wrap  <= s2_valid & s2_wrap;
            if (s2_valid) begin
                sin_out <= s2_sin_neg ? -sin_pos : sin_pos;
                cos_out <= s2_cos_neg ? -cos_pos : cos_pos;
            end
        end
    end

endmodule

// File: tb/tb_quad_swg.sv
// Directed testbench for quad_swg: reset, latency, period/wrap, symbol offset,
// en gaps, mid-stream reset and a full phase sweep against a real-valued model.
module tb_quad_swg;

    localparam int  DW  = 11;
    localparam int  PW  = 16;
    localparam int  LAW = 6;
    localparam int  AMP = 1000;
    localparam int  N   = 1 << LAW;
    localparam real PI  = 3.14159265358979323846;

    logic                 Clk = 1'b0;
    logic                 Rst;
    logic                 en;
    logic                 sym_load;
    logic [PW-1:0]        freq_word;
    logic [PW-1:0]        phase_off;
    logic signed [DW-1:0] sin_out;
    logic signed [DW-1:0] cos_out;
    logic                 valid;
    logic                 wrap;

    int total = 0;
    int bad   = 0;

    logic [PW-1:0] m_acc;
    logic [PW-1:0] m_off;
    logic          h_v [3];
    logic [PW-1:0] h_p [3];
    logic          h_w [3];
    int            m_sin;
    int            m_cos;
    logic          m_valid;
    logic          m_wrap;

    quad_swg #(
        .DW  (DW),
        .PW  (PW),
        .LAW (LAW),
        .AMP (AMP)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .en        (en),
        .freq_word (freq_word),
        .phase_off (phase_off),
        .sym_load  (sym_load),
        .sin_out   (sin_out),
        .cos_out   (cos_out),
        .valid     (valid),
        .wrap      (wrap)
    );

    always #5 Clk = ~Clk;

    function automatic int tval(input int k);
        return $rtoi(real'(AMP) * $sin(PI * real'(2 * k + 1) / real'(4 * N)) + 0.5);
    endfunction

    function automatic int model_sin(input logic [PW-1:0] p);
        logic [1:0] q;
        int         k;
        q = p[PW-1 -: 2];
        k = int'(p[PW-3 -: LAW]);
        case (q)
            2'd0:    return tval(k);
            2'd1:    return tval(N - 1 - k);
            2'd2:    return -tval(k);
            default: return -tval(N - 1 - k);
        endcase
    endfunction

    function automatic int model_cos(input logic [PW-1:0] p);
        logic [PW-1:0] pc;
        pc = p + (PW'(1) << (PW - 2));
        return model_sin(pc);
    endfunction

    // Drive one clock of inputs, then advance the behavioural model to match.
    task automatic applyStimulus(input logic r, input logic e, input logic [PW-1:0] fw,
                                 input logic sl, input logic [PW-1:0] po);
        logic [PW:0] sum;
        Rst       = r;
        en        = e;
        freq_word = fw;
        sym_load  = sl;
        phase_off = po;
        @(posedge Clk);
        #1;
        if (r) begin
            m_acc = '0;
            m_off = '0;
            for (int i = 0; i < 3; i++) begin
                h_v[i] = 1'b0;
                h_p[i] = '0;
                h_w[i] = 1'b0;
            end
            m_sin   = 0;
            m_cos   = 0;
            m_valid = 1'b0;
            m_wrap  = 1'b0;
        end else begin
            sum    = {1'b0, m_acc} + {1'b0, fw};
            h_v[2] = h_v[1]; h_p[2] = h_p[1]; h_w[2] = h_w[1];
            h_v[1] = h_v[0]; h_p[1] = h_p[0]; h_w[1] = h_w[0];
            h_v[0] = e;
            h_p[0] = m_acc + m_off;
            h_w[0] = e & sum[PW];
            if (e)  m_acc = sum[PW-1:0];
            if (sl) m_off = po;
            m_valid = h_v[2];
            m_wrap  = h_v[2] & h_w[2];
            if (h_v[2]) begin
                m_sin = model_sin(h_p[2]);
                m_cos = model_cos(h_p[2]);
            end
        end
    endtask

    task automatic checkOutput(input string tag, input logic signed [31:0] obs,
                               input logic signed [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".valid"}, valid, m_valid);
        checkOutput({tag, ".wrap"}, wrap, m_wrap);
        checkOutput({tag, ".sin"}, sin_out, m_sin);
        checkOutput({tag, ".cos"}, cos_out, m_cos);
    endtask

    initial begin
        int  m;
        int  e_sq;
        logic exp_gap [8];
        logic en_pat  [8];

        $display("[TB] quad_swg directed test start");

        // Reset, including en/sym_load asserted alongside it.
        applyStimulus(1'b1, 1'b0, '0, 1'b0, '0);
        applyStimulus(1'b1, 1'b1, 16'h1234, 1'b1, 16'h5555);
        checkOutput("rst.valid", valid, 0);
        checkOutput("rst.wrap", wrap, 0);
        checkOutput("rst.sin", sin_out, 0);
        checkOutput("rst.cos", cos_out, 0);

        // First launch after reset is phase 0; latency is three cycles.
        applyStimulus(1'b0, 1'b1, '0, 1'b0, '0);
        checkOutput("lat.c1.valid", valid, 0);
        applyStimulus(1'b0, 1'b1, '0, 1'b0, '0);
        checkOutput("lat.c2.valid", valid, 0);
        applyStimulus(1'b0, 1'b1, '0, 1'b0, '0);
        checkOutput("first.valid", valid, 1);
        checkOutput("first.sin", sin_out, 12);
        checkOutput("first.cos", cos_out, 1000);
        checkOutput("first.wrap", wrap, 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, '0, 1'b0, '0);
            checkOutput("const.valid", valid, 1);
            checkOutput("const.sin", sin_out, 12);
            checkAll("const");
        end

        // freq_word 1024: 64-sample period, wrap on every 64th valid.
        applyStimulus(1'b1, 1'b0, '0, 1'b0, '0);
        for (int n = 0; n < 68; n++) begin
            applyStimulus(1'b0, 1'b1, 16'd1024, 1'b0, '0);
            if (n >= 2) begin
                m = n - 2;
                checkAll("fw1024");
                if (m == 16) begin
                    checkOutput("peak16.sin", sin_out, 1000);
                    checkOutput("peak16.cos", cos_out, -12);
                end
                if (m == 62) checkOutput("wrap62", wrap, 0);
                if (m == 63) checkOutput("wrap63", wrap, 1);
                if (m == 64) checkOutput("period64.sin", sin_out, 12);
            end
        end

        // Symbol offset of half a cycle; load coincides with launch 8.
        applyStimulus(1'b1, 1'b0, '0, 1'b0, '0);
        for (int n = 0; n < 20; n++) begin
            applyStimulus(1'b0, 1'b1, 16'd1024, (n == 8), (n == 8) ? 16'h8000 : 16'h0000);
            if (n >= 2) begin
                m = n - 2;
                checkAll("off");
                if (m == 8)
                    checkOutput("off.simul", sin_out, model_sin(PW'(1024 * m)));
                if (m >= 9)
                    checkOutput("off.neg", sin_out, -model_sin(PW'(1024 * m)));
            end
        end

        // en pattern 1,0,1,1,0 with gaps: valid follows three cycles later.
        applyStimulus(1'b1, 1'b0, '0, 1'b0, '0);
        en_pat  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        exp_gap = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, en_pat[i], 16'd4096, 1'b0, '0);
            checkOutput("gap.valid", valid, exp_gap[i]);
            checkAll("gap");
            if (i == 3) checkOutput("gap.hold", sin_out, 12);
        end

        // Reset with two samples in flight; next launch restarts at phase 0.
        applyStimulus(1'b0, 1'b1, 16'd1024, 1'b1, 16'h8000);
        applyStimulus(1'b0, 1'b1, 16'd1024, 1'b0, '0);
        applyStimulus(1'b1, 1'b1, 16'd1024, 1'b1, 16'h8000);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 16'd1024, 1'b0, '0);
            checkOutput("flush.valid", valid, 0);
            checkAll("flush");
        end
        applyStimulus(1'b0, 1'b1, 16'd1024, 1'b0, '0);
        applyStimulus(1'b0, 1'b0, 16'd1024, 1'b0, '0);
        applyStimulus(1'b0, 1'b0, 16'd1024, 1'b0, '0);
        checkOutput("restart.valid", valid, 1);
        checkOutput("restart.sin", sin_out, 12);
        checkOutput("restart.cos", cos_out, 1000);

        // Sweep every table index in every quadrant and check amplitude.
        applyStimulus(1'b1, 1'b0, '0, 1'b0, '0);
        for (int n = 0; n < (1 << (LAW + 2)) + 2; n++) begin
            applyStimulus(1'b0, 1'b1, PW'(1 << (PW - LAW - 2)), 1'b0, '0);
            if (n >= 2) begin
                checkAll("sweep");
                e_sq = int'(sin_out) * int'(sin_out) + int'(cos_out) * int'(cos_out);
                checkOutput("sweep.energy", (e_sq >= 980000 && e_sq <= 1020000), 1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
